// File: rtl/signed_sub_serial.sv
// Bit-serial signed subtractor: a - b computed LSB first as a + ~b + 1,
// one bit per clock, with a three-state IDLE/BUSY/DONE handshake.
module signed_sub_serial #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             overflow
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           next_state_s;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] diff_r;
  logic [CW-1:0]    cnt_r;
  logic             carry_r;
  logic             ovf_r;
  logic             busy_r;
  logic             done_r;
  logic             accept_s;
  logic             last_s;
  logic             nb_s;
  logic             sum_s;
  logic             cout_s;

  // Full-adder slice on the current operand bits, subtrahend inverted
  always_comb begin
    nb_s   = ~b_sh_r[0];
    sum_s  = a_sh_r[0] ^ nb_s ^ carry_r;
    cout_s = (a_sh_r[0] & nb_s) | (a_sh_r[0] & carry_r) | (nb_s & carry_r);
    last_s = (state_r == ST_BUSY) && (cnt_r == CW'(WIDTH - 1));
  end

  // Next-state logic; start is only honoured outside BUSY
  always_comb begin
    next_state_s = state_r;
    accept_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          accept_s     = 1'b1;
          next_state_s = ST_BUSY;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (last_s) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_BUSY;
        end
      end
      ST_DONE: begin
        if (start) begin
          accept_s     = 1'b1;
          next_state_s = ST_BUSY;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // State register with registered busy/done flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      busy_r  <= (next_state_s == ST_BUSY);
      done_r  <= (next_state_s == ST_DONE);
    end
  end

  // Serial datapath; results publish only on the final bit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh_r  <= {WIDTH{1'b0}};
      b_sh_r  <= {WIDTH{1'b0}};
      acc_r   <= {WIDTH{1'b0}};
      diff_r  <= {WIDTH{1'b0}};
      cnt_r   <= {CW{1'b0}};
      carry_r <= 1'b0;
      ovf_r   <= 1'b0;
    end else if (accept_s) begin
      a_sh_r  <= a;
      b_sh_r  <= b;
      carry_r <= 1'b1;
      cnt_r   <= {CW{1'b0}};
    end else if (state_r == ST_BUSY) begin
      a_sh_r  <= a_sh_r >> 1;
      b_sh_r  <= b_sh_r >> 1;
      acc_r   <= {sum_s, acc_r[WIDTH-1:1]};
      carry_r <= cout_s;
      cnt_r   <= cnt_r + CW'(1);
      if (last_s) begin
        diff_r <= {sum_s, acc_r[WIDTH-1:1]};
        // carry_r here is the carry into the MSB
        ovf_r  <= carry_r ^ cout_s;
      end
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign diff     = diff_r;
  assign overflow = ovf_r;

endmodule

// File: doc/signed_sub_serial.md
SIGNED_SUB_SERIAL -- requirements
Module: signed_sub_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the operand and result width in bits (two's complement); legal range is 2..32.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit: request to begin a subtraction; sampled only when not busy.
REQ-005 SHALL have port a, input, WIDTH bits: signed minuend; sampled only on an accepted start.
REQ-006 SHALL have port b, input, WIDTH bits: signed subtrahend; sampled only on an accepted start.
REQ-007 SHALL have port busy, output, 1 bit: high while the operation is in progress.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse when diff and overflow become valid.
REQ-009 SHALL have port diff, output, WIDTH bits: a - b modulo 2^WIDTH.
REQ-010 SHALL have port overflow, output, 1 bit: high when the true signed difference is outside [-2^(WIDTH-1), 2^(WIDTH-1)-1].

Function
REQ-011 SHALL use a three-state FSM (IDLE, BUSY, DONE) and compute bit-serially, LSB first, one bit per clock, as a + ~b + 1.
REQ-012 SHALL accept start only in IDLE or DONE; acceptance captures a and b, sets the carry flop to 1, loads the bit counter with 0, and moves to BUSY.
REQ-013 SHALL ignore start while in BUSY; the captured operands are not disturbed.
REQ-014 SHALL process bit i at the i-th rising edge in BUSY: sum bit = a[i] ^ ~b[i] ^ carry; carry is updated to the full-adder carry-out.
REQ-015 SHALL hold busy high for exactly WIDTH cycles following the accepting edge.
REQ-016 SHALL move to DONE after the WIDTH-th bit and assert done for exactly one cycle; latency from the accepting edge to done high is WIDTH+1 rising edges.
REQ-017 SHALL update diff and overflow on the same edge that done rises, and hold both stable until the next accepted start completes.
REQ-018 SHALL NOT show partial results on diff during BUSY; diff keeps the previous result.
REQ-019 SHALL compute overflow as (carry into MSB) XOR (carry out of MSB); equivalently, a[MSB] != b[MSB] and diff[MSB] != a[MSB].
REQ-020 SHALL treat DONE without start as returning to IDLE on the next edge.
REQ-021 SHALL, for start in DONE, return to BUSY directly (back-to-back operation with no idle gap); done stays a one-cycle pulse.
REQ-022 SHALL treat the most negative value as an ordinary operand; 0 - (-2^(WIDTH-1)) yields overflow=1, diff=-2^(WIDTH-1).

Reset
REQ-023 SHALL, on rst_n low at a rising edge, force state IDLE, busy=0, done=0, diff=0, overflow=0, carry=0, counter=0.
REQ-024 SHALL let reset take priority over start and abort any operation in progress; no done is produced for an aborted operation.
REQ-025 SHALL accept start on the first edge with rst_n high.

Verification (WIDTH=4)
REQ-026 SHALL cover a=5, b=3, start one cycle -> busy 4 cycles, then done pulse with diff=2, overflow=0.
REQ-027 SHALL cover a=3, b=-5 -> diff=4'b1000 (-8), overflow=1; a=-8, b=1 -> diff=7, overflow=1.
REQ-028 SHALL cover a=-4, b=4 -> diff=-8, overflow=0; a=0, b=-8 -> diff=-8, overflow=1.
REQ-029 SHALL cover start and a change of a/b during BUSY -> ignored, and the result matches the originally captured operands.
REQ-030 SHALL cover back-to-back start in the DONE cycle (6-2, then -1-(-1)) -> two done pulses WIDTH+1 edges apart, with diff=4 then diff=0, overflow=0.
REQ-031 SHALL cover rst_n low in the 2nd BUSY cycle -> all outputs 0 on the next edge, no done pulse, and a new start is accepted after release.
REQ-032 SHALL include an exhaustive sweep of all 256 (a, b) pairs compared against a reference signed subtraction for diff and overflow.
